uart_tx_word_feeder: RTL and testbench

Buffers multi-byte words from the core or debug unit and feeds them, one byte at a time, to the UART byte transmitter. Words enter through a valid/ready port into a small FIFO. A sequencer splits each word LSB-byte-first, pulses the transmitter's start input and waits for its done tick before the next byte. It sits directly upstream of the serial transmitter in the UART path.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_word_feeder_if.sv | 28 ++
 rtl/uart_tx_word_feeder_fifo.sv | 53 +++++
 rtl/uart_tx_word_feeder.sv | 102 ++++++++++
 tb/tb_uart_tx_word_feeder.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and sequencer state encoding.
package uart_pkg;

  localparam int NB_BYTE  = 8;
  localparam int NB_STATE = 2;

  typedef enum logic [NB_STATE-1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10
  } state_t;

endpackage

// File: rtl/uart_tx_word_feeder_if.sv
// Word-input and byte-transmitter handshake bundle for uart_tx_word_feeder.
interface uart_tx_word_feeder_if #(
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 2,
  parameter int NB_BYTE = 8
);

  logic               i_word_valid;
  logic [NB_WORD-1:0] i_word;
  logic               o_word_ready;
  logic               o_tx_start;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               i_tx_done_tick;
  logic               o_word_done;
  logic               o_busy;
  logic [NB_ADDR:0]   o_level;

  modport master (
    output i_word_valid, i_word, i_tx_done_tick,
    input  o_word_ready, o_tx_start, o_tx_data, o_word_done, o_busy, o_level
  );

  modport slave (
    input  i_word_valid, i_word, i_tx_done_tick,
    output o_word_ready, o_tx_start, o_tx_data, o_word_done, o_busy, o_level
  );

endinterface

// File: rtl/uart_tx_word_feeder_fifo.sv
// Synchronous FIFO with occupancy count; pop data is read combinationally at the read pointer.
module sync_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [NB_DATA-1:0] push_data,
  input  logic               pop,
  output logic [NB_DATA-1:0] pop_data,
  output logic               full,
  output logic               empty,
  output logic [NB_ADDR:0]   level
);

  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == (NB_ADDR+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_word_feeder.sv
// Buffers words in a FIFO and feeds them LSB-byte-first to a byte transmitter
// using a start pulse / done tick handshake.
module uart_tx_word_feeder #(
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 2,
  parameter int NB_BYTE = uart_pkg::NB_BYTE
) (
  input logic i_clock,
  input logic i_reset_n,
  uart_tx_word_feeder_if.slave bus
);

  import uart_pkg::*;

  localparam int NB_BYTES = NB_WORD / NB_BYTE;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  state_t              state;
  state_t              state_next;
  logic [NB_WORD-1:0]  word_reg;
  logic [NB_WORD-1:0]  word_next;
  logic [NB_CNT-1:0]   byte_cnt;
  logic [NB_CNT-1:0]   cnt_next;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [NB_WORD-1:0]  fifo_data;
  logic                tx_start;
  logic                word_done;

  sync_fifo #(
    .NB_DATA (NB_WORD),
    .NB_ADDR (NB_ADDR)
  ) u_fifo (
    .clk       (i_clock),
    .rst_n     (i_reset_n),
    .push      (bus.i_word_valid),
    .push_data (bus.i_word),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (bus.o_level)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      word_reg <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_next;
      word_reg <= word_next;
      byte_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    word_next  = word_reg;
    cnt_next   = byte_cnt;
    fifo_pop   = 1'b0;
    tx_start   = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_next  = fifo_data;
          cnt_next   = '0;
          state_next = START;
        end
      end
      START: begin
        tx_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // Done ticks are only honoured here; the word register shifts on
        // the tick so the next byte is already in place for START.
        if (bus.i_tx_done_tick) begin
          if (byte_cnt == NB_CNT'(NB_BYTES - 1)) begin
            word_done  = 1'b1;
            state_next = IDLE;
          end else begin
            word_next  = word_reg >> NB_BYTE;
            cnt_next   = byte_cnt + 1'b1;
            state_next = START;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.o_word_ready = !fifo_full;
  assign bus.o_tx_start   = tx_start;
  assign bus.o_tx_data    = word_reg[NB_BYTE-1:0];
  assign bus.o_word_done  = word_done;
  assign bus.o_busy       = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Directed/randomized bench for uart_tx_word_feeder with a byte-stream reference model
// and a transmitter model that returns a done tick a fixed delay after each start.
module tb_uart_tx_word_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_word_feeder_if #(.NB_WORD(32), .NB_ADDR(2), .NB_BYTE(8)) bus ();
  uart_tx_word_feeder_if #(.NB_WORD(16), .NB_ADDR(2), .NB_BYTE(8)) bus16 ();

  uart_tx_word_feeder #(.NB_WORD(32), .NB_ADDR(2), .NB_BYTE(8)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  uart_tx_word_feeder #(.NB_WORD(16), .NB_ADDR(2), .NB_BYTE(8)) dut16 (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus16)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Transmitter model and output monitor
  int         cyc = 0;
  int         tx_cnt = 0;
  int         tx_delay = 20;
  logic       tx_done = 1'b0;
  logic       spur = 1'b0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  int         wd_cnt = 0;
  int         exp_words = 0;
  int         done_cnt = 0;
  int         overlap = 0;
  int         max_level = 0;

  assign bus.i_tx_done_tick = tx_done | spur;

  always @(posedge clk) begin
    cyc++;
    #1;
    tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        done_cnt++;
      end
    end
    #1;
    if (!rst_n) begin
      tx_cnt = 0;
    end else begin
      if (bus.o_tx_start === 1'b1) begin
        if (tx_cnt != 0) overlap++;
        obs_q.push_back(bus.o_tx_data);
        start_cyc.push_back(cyc);
        tx_cnt = tx_delay;
      end
      if (bus.o_word_done === 1'b1) wd_cnt++;
      if (int'(bus.o_level) > max_level) max_level = int'(bus.o_level);
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
    exp_words++;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((bus.o_busy !== 1'b0 || tx_cnt != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < limit), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    wait_idle(3000);
    check($sformatf("%s_nbytes", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
    check($sformatf("%s_words", tag), wd_cnt, exp_words);
    check($sformatf("%s_overlap", tag), overlap, 0);
    obs_q.delete();
    exp_q.delete();
    start_cyc.delete();
    wd_cnt = 0;
    exp_words = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.o_word_ready, 1);
    check({tag, "_start"}, bus.o_tx_start, 0);
    check({tag, "_data"},  bus.o_tx_data, 0);
    check({tag, "_wdone"}, bus.o_word_done, 0);
    check({tag, "_busy"},  bus.o_busy, 0);
    check({tag, "_level"}, bus.o_level, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[5];
    logic        acc;
    int          n;
    int          base;

    bus.i_word_valid   = 1'b0;
    bus.i_word         = '0;
    bus16.i_word_valid = 1'b0;
    bus16.i_word       = '0;
    bus16.i_tx_done_tick = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single word, byte order and latency
    @(posedge clk); #1;
    bus.i_word_valid = 1'b1;
    bus.i_word = 32'h11223344;
    push_word(32'h11223344);
    @(posedge clk); #1 bus.i_word_valid = 1'b0;
    @(negedge clk);
    check("t1_level1", bus.o_level, 1);
    check("t1_nostart", bus.o_tx_start, 0);
    check("t1_busy", bus.o_busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_start", bus.o_tx_start, 1);
    check("t1_data0", bus.o_tx_data, 8'h44);
    check("t1_level0", bus.o_level, 0);
    wait_idle(3000);
    for (int i = 0; i + 1 < start_cyc.size(); i++)
      check($sformatf("t1_gap%0d", i), start_cyc[i+1] - start_cyc[i], tx_delay + 1);
    check_stream("t1");

    // Overflow: one word in flight, then five offered back to back
    @(posedge clk); #1;
    bus.i_word_valid = 1'b1;
    bus.i_word = 32'hA0A1A2A3;
    push_word(32'hA0A1A2A3);
    @(posedge clk); #1 bus.i_word_valid = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.i_word_valid = 1'b1;
      bus.i_word = w[i];
      @(negedge clk);
      check($sformatf("t2_ready%0d", i), bus.o_word_ready, (i < 4) ? 1 : 0);
      if (i < 4) push_word(w[i]);
    end
    check("t2_level_full", bus.o_level, 4);
    n = 0;
    while (bus.o_word_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t2_ready_timeout", 32'(n < 300), 1);
    check("t2_level_after_pop", bus.o_level, 3);
    push_word(w[4]);
    @(posedge clk); #1 bus.i_word_valid = 1'b0;
    check_stream("t2");

    // Continuous valid: push on pop
    tx_delay = 3;
    max_level = 0;
    @(posedge clk); #1;
    bus.i_word_valid = 1'b1;
    bus.i_word = $urandom;
    repeat (60) begin
      @(negedge clk);
      acc = bus.o_word_ready;
      @(posedge clk); #1;
      if (acc) begin
        push_word(bus.i_word);
        bus.i_word = $urandom;
      end
    end
    bus.i_word_valid = 1'b0;
    check_stream("t3");
    check("t3_max_level", 32'(max_level <= 4), 1);

    // Spurious done ticks in IDLE and START
    tx_delay = 20;
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t4_idle_nostart", obs_q.size(), 0);
    check("t4_idle_busy", bus.o_busy, 0);
    @(posedge clk); #1;
    bus.i_word_valid = 1'b1;
    bus.i_word = 32'hC0FFEE42;
    push_word(32'hC0FFEE42);
    @(posedge clk); #1 bus.i_word_valid = 1'b0;
    @(posedge clk); #1 spur = 1'b1;
    @(negedge clk);
    check("t4_start", bus.o_tx_start, 1);
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    check("t4_wait_nostart", bus.o_tx_start, 0);
    check_stream("t4");

    // Reset after the second byte drops the partial word and the queued one
    @(posedge clk); #1;
    bus.i_word_valid = 1'b1;
    bus.i_word = 32'hAABBCCDD;
    @(posedge clk); #1;
    bus.i_word = 32'h55667788;
    @(posedge clk); #1 bus.i_word_valid = 1'b0;
    base = done_cnt;
    n = 0;
    while (done_cnt < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_done_timeout", 32'(n < 200), 1);
    check("t5_level_before", bus.o_level, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5");
    check("t5_nbytes", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      check("t5_b0", obs_q[0], 8'hDD);
      check("t5_b1", obs_q[1], 8'hCC);
    end
    obs_q.delete();
    start_cyc.delete();
    wd_cnt = 0;
    @(posedge clk); #1;
    bus.i_word_valid = 1'b1;
    bus.i_word = 32'h01020304;
    push_word(32'h01020304);
    @(posedge clk); #1 bus.i_word_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_new_start", bus.o_tx_start, 1);
    check("t5_new_data", bus.o_tx_data, 8'h04);
    check_stream("t5");

    // 16-bit word: two starts, busy drops after word_done
    @(posedge clk); #1;
    bus16.i_word_valid = 1'b1;
    bus16.i_word = 16'hBEEF;
    @(posedge clk); #1 bus16.i_word_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_start0", bus16.o_tx_start, 1);
    check("t6_data0", bus16.o_tx_data, 8'hEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_wait_nostart", bus16.o_tx_start, 0);
    check("t6_data_stable", bus16.o_tx_data, 8'hEF);
    @(posedge clk); #1 bus16.i_tx_done_tick = 1'b1;
    @(negedge clk);
    check("t6_no_wdone0", bus16.o_word_done, 0);
    @(posedge clk); #1 bus16.i_tx_done_tick = 1'b0;
    @(negedge clk);
    check("t6_start1", bus16.o_tx_start, 1);
    check("t6_data1", bus16.o_tx_data, 8'hBE);
    repeat (2) @(posedge clk);
    #1 bus16.i_tx_done_tick = 1'b1;
    @(negedge clk);
    check("t6_wdone", bus16.o_word_done, 1);
    check("t6_busy_at_done", bus16.o_busy, 1);
    @(posedge clk); #1 bus16.i_tx_done_tick = 1'b0;
    @(negedge clk);
    check("t6_busy_low", bus16.o_busy, 0);
    check("t6_wdone_low", bus16.o_word_done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_no_third_start", bus16.o_tx_start, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
